// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI-lite single-beat responder backed by a word-addressed SRAM array. It is
// the memory end of the CPU-side read/write arbiter and doubles as the
// simulation memory model. Reads and writes run in independent FSMs, each with
// its own programmable wait-state count.
//
// Parameters:
//   DEPTH     number of 32-bit words (power of two)
//   BASE      byte address of word 0
//   RD_LAT    wait cycles between AR handshake and rvalid (0..15)
//   WR_LAT    wait cycles between AW+W capture and bvalid (0..15)
//   INIT_FILE hex image name (kept for interface compatibility)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   araddr/arvalid/arready   read address channel
//   rdata/rresp/rvalid/rready read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel (wstrb[i] covers byte i)
//   bresp/bvalid/bready      write response channel (00 OKAY, 10 SLVERR)
//
// Optional feature macro: AXI_SRAM_LFSR_DELAY_EN
//   When defined, a 16-bit LFSR adds 0..3 random wait cycles per transaction
//   and randomly masks arready/awready while idle. The sequence restarts from
//   the same seed on every reset.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE      = 32'h8000_0000,
   parameter int          RD_LAT    = 1,
   parameter int          WR_LAT    = 1,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          IDX_W       = $clog2(DEPTH);
   localparam logic [32:0] SPAN        = 33'(DEPTH) << 2'd2;
   localparam logic [3:0]  RD_LAT_C    = 4'(RD_LAT);
   localparam logic [3:0]  WR_LAT_C    = 4'(WR_LAT);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   // The wait counters are 4 bits wide, so larger latencies cannot be honoured.
   if (RD_LAT < 0 || RD_LAT > 15) begin : g_rd_lat_err
      $error("axi_sram_slave: RD_LAT=%0d outside 0..15", RD_LAT);
   end
   if (WR_LAT < 0 || WR_LAT > 15) begin : g_wr_lat_err
      $error("axi_sram_slave: WR_LAT=%0d outside 0..15", WR_LAT);
   end

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   // Wait count for a new transaction: configured latency plus jitter,
   // saturated so it always fits the 4-bit counter.
   function automatic logic [3:0] wait_count(input logic [3:0] lat, input logic [1:0] extra);
      logic [4:0] sum;
      sum = {1'b0, lat} + {3'b000, extra};
      if (sum[4]) begin
         return 4'hF;
      end else begin
         return sum[3:0];
      end
   endfunction

   logic [31:0] mem [DEPTH];

   rd_state_t        rd_state_r;
   logic [3:0]       rd_cnt_r;
   logic             rd_ok_r;
   logic [IDX_W-1:0] rd_idx_r;

   wr_state_t        wr_state_r;
   logic [3:0]       wr_cnt_r;
   logic             wr_ok_r;
   logic [IDX_W-1:0] wr_idx_r;
   logic [31:0]      wr_data_r;
   logic [3:0]       wr_strb_r;
   logic             aw_got_r;
   logic             w_got_r;

   logic             run_r;
   logic             accept_s;
   logic [1:0]       extra_s;

   logic [31:0]      ar_off_s;
   logic             ar_ok_s;
   logic [IDX_W-1:0] ar_idx_s;
   logic [31:0]      aw_off_s;
   logic             aw_ok_s;
   logic [IDX_W-1:0] aw_idx_s;

   logic             ar_hs_s;
   logic             aw_hs_s;
   logic             w_hs_s;
   logic             aw_have_s;
   logic             w_have_s;
   logic             wr_commit_s;
   logic [3:0]       rd_load_s;
   logic [3:0]       wr_load_s;

   // Readies stay low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

`ifdef AXI_SRAM_LFSR_DELAY_EN
   logic [15:0] lfsr_r;
   logic        lfsr_fb_s;

   // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
   assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

   // Free-running jitter source, reseeded on every reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
      end
   end

   assign extra_s  = lfsr_r[1:0];
   assign accept_s = run_r & lfsr_r[2];
`else
   assign extra_s  = 2'd0;
   assign accept_s = run_r;
`endif

   // Address decode: the offset is compared over its full width so addresses
   // at or above BASE + 4*DEPTH never alias back into the array.
   assign ar_off_s = araddr - BASE;
   assign ar_ok_s  = (araddr >= BASE) && ({1'b0, ar_off_s} < SPAN);
   assign ar_idx_s = ar_off_s[IDX_W+1:2];
   assign aw_off_s = awaddr - BASE;
   assign aw_ok_s  = (awaddr >= BASE) && ({1'b0, aw_off_s} < SPAN);
   assign aw_idx_s = aw_off_s[IDX_W+1:2];

   // Readies are decoded from registered state only.
   assign arready = (rd_state_r == R_IDLE) && accept_s;
   assign awready = (wr_state_r == W_IDLE) && !aw_got_r && accept_s;
   assign wready  = (wr_state_r == W_IDLE) && !w_got_r && run_r;

   assign ar_hs_s   = arvalid && arready;
   assign aw_hs_s   = awvalid && awready;
   assign w_hs_s    = wvalid && wready;
   assign aw_have_s = aw_got_r || aw_hs_s;
   assign w_have_s  = w_got_r || w_hs_s;
   assign rd_load_s = wait_count(RD_LAT_C, extra_s);
   assign wr_load_s = wait_count(WR_LAT_C, extra_s);

   // The array write happens on the same edge that raises bvalid.
   assign wr_commit_s = (wr_state_r == W_WAIT) && (wr_cnt_r == 4'd0) && wr_ok_r;

   // Byte-lane writes into the array on the commit edge.
   always_ff @(posedge clk) begin
      if (wr_commit_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb_r[b]) begin
               mem[wr_idx_r][8*b +: 8] <= wr_data_r[8*b +: 8];
            end
         end
      end
   end

   // Read FSM. The counter holds the remaining wait edges; once it is zero the
   // next edge samples the array and raises rvalid, i.e. RD_LAT+1 edges after
   // the AR handshake. Sampling uses the pre-edge array, so a write committing
   // on that same edge is not yet visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state_r <= R_IDLE;
         rd_cnt_r   <= 4'd0;
         rd_ok_r    <= 1'b0;
         rd_idx_r   <= '0;
         rdata      <= 32'h0000_0000;
         rresp      <= RESP_OKAY;
         rvalid     <= 1'b0;
      end else begin
         case (rd_state_r)
            R_IDLE: begin
               if (ar_hs_s) begin
                  rd_ok_r    <= ar_ok_s;
                  rd_idx_r   <= ar_idx_s;
                  rd_cnt_r   <= rd_load_s;
                  rd_state_r <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (rd_cnt_r == 4'd0) begin
                  rdata      <= rd_ok_r ? mem[rd_idx_r] : 32'h0000_0000;
                  rresp      <= rd_ok_r ? RESP_OKAY : RESP_SLVERR;
                  rvalid     <= 1'b1;
                  rd_state_r <= R_RESP;
               end else begin
                  rd_cnt_r <= rd_cnt_r - 4'd1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid     <= 1'b0;
                  rd_state_r <= R_IDLE;
               end
            end
            default: begin
               rvalid     <= 1'b0;
               rd_state_r <= R_IDLE;
            end
         endcase
      end
   end

   // Write FSM. AW and W are captured independently in W_IDLE; once both are
   // held the wait count is loaded, and bvalid rises WR_LAT+1 edges after the
   // capture that completed the pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_state_r <= W_IDLE;
         wr_cnt_r   <= 4'd0;
         wr_ok_r    <= 1'b0;
         wr_idx_r   <= '0;
         wr_data_r  <= 32'h0000_0000;
         wr_strb_r  <= 4'h0;
         aw_got_r   <= 1'b0;
         w_got_r    <= 1'b0;
         bresp      <= RESP_OKAY;
         bvalid     <= 1'b0;
      end else begin
         case (wr_state_r)
            W_IDLE: begin
               if (aw_hs_s) begin
                  wr_ok_r  <= aw_ok_s;
                  wr_idx_r <= aw_idx_s;
                  aw_got_r <= 1'b1;
               end
               if (w_hs_s) begin
                  wr_data_r <= wdata;
                  wr_strb_r <= wstrb;
                  w_got_r   <= 1'b1;
               end
               if (aw_have_s && w_have_s) begin
                  wr_cnt_r   <= wr_load_s;
                  wr_state_r <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (wr_cnt_r == 4'd0) begin
                  bresp      <= wr_ok_r ? RESP_OKAY : RESP_SLVERR;
                  bvalid     <= 1'b1;
                  wr_state_r <= W_RESP;
               end else begin
                  wr_cnt_r <= wr_cnt_r - 4'd1;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid     <= 1'b0;
                  aw_got_r   <= 1'b0;
                  w_got_r    <= 1'b0;
                  wr_state_r <= W_IDLE;
               end
            end
            default: begin
               bvalid     <= 1'b0;
               aw_got_r   <= 1'b0;
               w_got_r    <= 1'b0;
               wr_state_r <= W_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed and randomized bench for axi_sram_slave with default parameters
// (DEPTH=4096, BASE=0x8000_0000, RD_LAT=WR_LAT=1). Expected read data and
// responses come from a word-indexed associative-array memory model.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

   localparam logic [31:0] M_BASE = 32'h8000_0000;
   localparam logic [31:0] M_END  = 32'h8000_4000;
   localparam int          EXP_RD = 2;
   localparam int          EXP_WR = 2;

   logic        clk;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [int];

   axi_sram_slave dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_ok(input logic [31:0] a);
      return (a >= M_BASE) && (a < M_END);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - M_BASE) / 32'd4);
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (m_ok(a)) begin
         w = model_mem.exists(m_idx(a)) ? model_mem[m_idx(a)] : 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         end
         model_mem[m_idx(a)] = w;
      end
   endtask

   function automatic logic [31:0] m_rdata(input logic [31:0] a);
      if (!m_ok(a)) return 32'h0;
      return model_mem.exists(m_idx(a)) ? model_mem[m_idx(a)] : 32'h0;
   endfunction

   function automatic logic [1:0] m_resp(input logic [31:0] a);
      return m_ok(a) ? 2'b00 : 2'b10;
   endfunction

   // ---------------- bus tasks (called at posedge + 1) ----------------
   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int w_start, input int aw_start,
                           input bit chk_order);
      int t;
      int lat;
      bit aw_done, w_done, aw_fire, w_fire, order_done;
      t = 0; aw_done = 0; w_done = 0; order_done = 0;
      awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
      while (!(aw_done && w_done) && t < 50) begin
         awvalid = !aw_done && (t >= aw_start);
         wvalid  = !w_done && (t >= w_start);
         if (chk_order && w_done && !aw_done && !order_done) begin
            chk({tag, "_awready_open"}, 32'(awready), 32'd1);
            chk({tag, "_wready_closed"}, 32'(wready), 32'd0);
            order_done = 1;
         end
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_fire) aw_done = 1;
         if (w_fire)  w_done  = 1;
         t++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk({tag, "_aw_w_accept"}, 32'(aw_done && w_done), 32'd1);
      lat = 0;
      while (!bvalid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_b_latency"}, 32'(lat), 32'(EXP_WR));
      chk({tag, "_bresp"}, 32'(bresp), 32'(m_resp(a)));
      m_write(a, d, s);
      @(posedge clk); #1;
      chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
   endtask

   task automatic rd_issue(input string tag, input logic [31:0] a);
      int t;
      int lat;
      bit done, fire;
      t = 0; done = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      while (!done && t < 50) begin
         fire = arvalid && arready;
         @(posedge clk); #1;
         t++;
         if (fire) begin
            done = 1;
            arvalid = 1'b0;
         end
      end
      arvalid = 1'b0;
      chk({tag, "_ar_accept"}, 32'(done), 32'd1);
      lat = 0;
      while (!rvalid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_r_latency"}, 32'(lat), 32'(EXP_RD));
      chk({tag, "_rdata"}, rdata, m_rdata(a));
      chk({tag, "_rresp"}, 32'(rresp), 32'(m_resp(a)));
   endtask

   task automatic rd_hold(input string tag, input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
         chk({tag, "_hold_rdata"}, rdata, m_rdata(a));
         chk({tag, "_hold_arready"}, 32'(arready), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic rd_accept(input string tag);
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
      chk({tag, "_arready_back"}, 32'(arready), 32'd1);
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input int stall);
      rd_issue(tag, a);
      rd_hold(tag, a, stall);
      rd_accept(tag);
   endtask

   function automatic logic [31:0] pick_addr();
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) return M_BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
      if (sel == 8) return 32'h8000_3FFC;
      if ($urandom_range(0, 1) == 0) return M_END + 32'(4 * $urandom_range(0, 15));
      return 32'h7FFF_FFFC - 32'(4 * $urandom_range(0, 15));
   endfunction

   // ---------------- directed + randomized sequence ----------------
   initial begin
      logic [31:0] a;
      rst = 1'b0;
      araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
      awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
      bready = 1'b0;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_arready", 32'(arready), 32'd0);
         chk("rst_awready", 32'(awready), 32'd0);
         chk("rst_wready", 32'(wready), 32'd0);
         chk("rst_rvalid", 32'(rvalid), 32'd0);
         chk("rst_bvalid", 32'(bvalid), 32'd0);
         chk("rst_rdata", rdata, 32'h0);
         chk("rst_rresp", 32'(rresp), 32'd0);
         chk("rst_bresp", 32'(bresp), 32'd0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_arready", 32'(arready), 32'd1);
      chk("post_rst_awready", 32'(awready), 32'd1);
      chk("post_rst_wready", 32'(wready), 32'd1);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
      chk("post_rst_bvalid", 32'(bvalid), 32'd0);

      // Write then read back.
      do_write("wr_basic", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      do_read("rd_basic", 32'h8000_0010, 0);

      // W three cycles ahead of AW, partial strobes.
      do_write("wr_order", 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 3, 1);
      do_read("rd_order", 32'h8000_0010, 0);
      chk("rd_order_literal", m_rdata(32'h8000_0010), 32'hDE22_BE44);

      // Out-of-range accesses.
      do_write("wr_word0", 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
      do_read("rd_oor_low", 32'h7FFF_FFFC, 0);
      do_write("wr_oor_high", 32'h8000_4000, 32'h5555_AAAA, 4'hF, 0, 0, 0);
      do_read("rd_word0_kept", 32'h8000_0000, 0);

      // Read backpressure with a concurrent write.
      do_write("wr_bp_init", 32'h8000_0020, 32'h0102_0304, 4'hF, 0, 0, 0);
      rd_issue("bp", 32'h8000_0010);
      rd_hold("bp", 32'h8000_0010, 2);
      do_write("bp_wr", 32'h8000_0020, 32'hA5A5_5A5A, 4'hF, 1, 0, 0);
      rd_hold("bp", 32'h8000_0010, 2);
      rd_accept("bp");
      do_read("bp_wr_check", 32'h8000_0020, 0);

      // Reset while a read waits and W is captured with AW pending.
      araddr = 32'h8000_0010; arvalid = 1'b1;
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; awvalid = 1'b0;
      @(posedge clk); #1;
      arvalid = 1'b0; wvalid = 1'b0;
      chk("mid_arready", 32'(arready), 32'd0);
      chk("mid_wready", 32'(wready), 32'd0);
      chk("mid_awready", 32'(awready), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_arready", 32'(arready), 32'd0);
      chk("mid_rst_wready", 32'(wready), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_post_arready", 32'(arready), 32'd1);
      chk("mid_post_wready", 32'(wready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("mid_no_rvalid", 32'(rvalid), 32'd0);
         chk("mid_no_bvalid", 32'(bvalid), 32'd0);
         @(posedge clk); #1;
      end
      do_read("mid_rd_kept", 32'h8000_0010, 0);

      // Randomized traffic over a small initialised window.
      for (int k = 0; k < 8; k++) begin
         do_write("rnd_init", M_BASE + 32'(4 * k), $urandom, 4'hF, 0, 0, 0);
      end
      do_write("rnd_init_top", 32'h8000_3FFC, $urandom, 4'hF, 0, 0, 0);
      for (int n = 0; n < 40; n++) begin
         a = pick_addr();
         if ($urandom_range(0, 1) == 0) begin
            do_write("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
         end else begin
            do_read("rnd_rd", a, int'($urandom_range(0, 2)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
